// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : FIFO-buffered UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          uart_tx
);

  localparam int c_div = CLK_FREQ / BAUD;
  localparam int c_bw  = $clog2(c_div);
  localparam int c_pw  = $clog2(FIFO_DEPTH);
  localparam int c_cw  = c_pw + 1;
  localparam logic [c_bw-1:0] c_baud_max = c_bw'(c_div - 1);
  localparam logic [c_cw-1:0] c_depth    = c_cw'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [c_bw-1:0]   r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [c_pw-1:0]   r_wr_ptr;
  logic [c_pw-1:0]   r_rd_ptr;
  logic [c_cw-1:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic              w_shift_en;
  logic              w_tx_next;
  logic              w_baud_end;
  logic [c_cw-1:0]   w_count_next;
  logic [7:0]        w_head;

  // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign w_push     = wr_en & ~r_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_baud_end = (r_baud == c_baud_max);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_cw'(1);
      2'b01:   w_count_next = r_count - c_cw'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_pw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_pw'(1);
      end
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_depth);
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic also computes the next line level so the pin is a pure flop.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_shift_en   = 1'b0;
    w_tx_next    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (!r_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = r_parity;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_shift_en = 1'b1;
            w_tx_next  = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          if (!r_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_tx <= w_tx_next;
      if (w_pop || (r_state == S_IDLE) || w_baud_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + c_bw'(1);
      end
      if (w_pop) begin
        r_shift <= w_head;
        r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity <= ^w_head;
`endif
      end else if (w_shift_en) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE);
  assign uart_tx  = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// tb_uart_tx_fifo : bench for uart_tx_fifo against a frame-timer reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 400;
  localparam int BAUD     = 100;
  localparam int DIV      = 4;
  localparam int DEPTH    = 16;
  localparam int CW       = 5;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS    = 11;
`else
  localparam int NBITS    = 10;
`endif
  localparam int FL       = NBITS * DIV;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full, empty, busy, overflow, uart_tx;
  logic [CW-1:0] count;
  logic [9:0]    dut_vec;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .count    (count),
    .overflow (overflow),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  assign dut_vec = {uart_tx, busy, count, empty, full, overflow};

  // Reference model: a byte queue plus a frame timer counting cycles into the current frame.
  logic [7:0] m_q[$];
  logic       m_busy = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_cur  = 8'h00;
  logic       m_ovf  = 1'b0;
  int         m_n;
  logic       m_pop;

  function automatic logic line_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic logic [9:0] model_vec();
    logic tx;
    tx = m_busy ? line_bit(m_cur, m_t / DIV) : 1'b1;
    return {tx, m_busy, CW'(m_q.size()), (m_q.size() == 0), (m_q.size() == DEPTH), m_ovf};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_busy = 1'b0;
      m_t    = 0;
      m_ovf  = 1'b0;
    end else begin
      m_n   = m_q.size();
      m_pop = (m_n > 0) && (!m_busy || (m_t == FL - 1));
      if (m_pop) begin
        m_cur  = m_q.pop_front();
        m_busy = 1'b1;
        m_t    = 0;
      end else if (m_busy) begin
        if (m_t == FL - 1) m_busy = 1'b0;
        else               m_t = m_t + 1;
      end
      if (wr_en) begin
        if (m_n == DEPTH) m_ovf = 1'b1;
        else              m_q.push_back(wr_data);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if ({busy, full} !== 2'b00) begin failures++; $display("FAIL reset_busy_full got=%b exp=00", {busy, full}); end
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL idle_line tx=%b busy=%b exp tx=1 busy=0", uart_tx, busy);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [FL-1:0]    line_s;
    logic [NBITS-1:0] exp_bits;
    int               busy_cnt;
    logic             ok;
`ifdef UART_TX_PARITY_EN
    exp_bits = {1'b1, 1'b0, 8'h55, 1'b0};
`else
    exp_bits = {1'b1, 8'h55, 1'b0};
`endif
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk); wr_en = 1'b0;
    checks++;
    if (count !== CW'(1) || empty !== 1'b0 || uart_tx !== 1'b1) begin
      failures++; $display("FAIL write_latency count=%0d empty=%b tx=%b exp 1,0,1", count, empty, uart_tx);
    end
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL start_edge tx=%b busy=%b exp tx=0 busy=1", uart_tx, busy);
    end
    busy_cnt  = 1;
    line_s[0] = uart_tx;
    for (int k = 1; k < FL + 4; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL model_single t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
      if (busy === 1'b1) busy_cnt++;
      if (k < FL) line_s[k] = uart_tx;
    end
    for (int b = 0; b < NBITS; b++) begin
      ok = 1'b1;
      for (int s = 0; s < DIV; s++) if (line_s[b*DIV+s] !== exp_bits[b]) ok = 1'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL frame55_bit%0d got=%b exp=%b", b, line_s[b*DIV +: DIV], exp_bits[b]); end
    end
    checks++;
    if (busy_cnt != FL) begin failures++; $display("FAIL busy_len got=%0d exp=%0d", busy_cnt, FL); end
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    int gap;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h00;
    @(negedge clk); wr_data = 8'hFF;
    checks++;
    if (count !== CW'(1) || empty !== 1'b0) begin
      failures++; $display("FAIL b2b_first count=%0d empty=%b exp 1,0", count, empty);
    end
    @(negedge clk); wr_en = 1'b0;
    checks++;
    if (count !== CW'(1) || busy !== 1'b1 || uart_tx !== 1'b0) begin
      failures++; $display("FAIL b2b_pop1 count=%0d busy=%b tx=%b exp 1,1,0", count, busy, uart_tx);
    end
    busy_cnt = 1;
    gap      = 0;
    for (int k = 1; k < 2*FL + 4; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL model_b2b t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
      if (busy === 1'b1) busy_cnt++;
      if (k < 2*FL && busy !== 1'b1) gap++;
      if (k == FL) begin
        checks++;
        if (uart_tx !== 1'b0 || busy !== 1'b1 || count !== '0) begin
          failures++; $display("FAIL b2b_pop2 tx=%b busy=%b count=%0d exp 0,1,0", uart_tx, busy, count);
        end
      end
    end
    checks++;
    if (busy_cnt != 2*FL || gap != 0) begin
      failures++; $display("FAIL b2b_len busy=%0d gap=%0d exp busy=%0d gap=0", busy_cnt, gap, 2*FL);
    end
  endtask

  task automatic test_overflow();
    int busy_cnt;
    int n;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk); wr_en = 1'b0;
    busy_cnt = 0;
    n        = 0;
    while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ovf_busy_timeout busy=%b exp=1", busy); end
    busy_cnt = 1;
    for (int j = 0; j < 17; j++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (j == 16) begin
        checks++;
        if (full !== 1'b1 || count !== CW'(16) || overflow !== 1'b0) begin
          failures++; $display("FAIL ovf_fill full=%b count=%0d ovf=%b exp 1,16,0", full, count, overflow);
        end
      end
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
    end
    @(negedge clk);
    wr_en = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1 || count !== CW'(16)) begin
      failures++; $display("FAIL ovf_set ovf=%b full=%b count=%0d exp 1,1,16", overflow, full, count);
    end
    n = 0;
    while ((busy !== 1'b0 || empty !== 1'b1) && n < 20*FL) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) busy_cnt++;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL model_ovf t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    checks++;
    if (n >= 20*FL) begin failures++; $display("FAIL ovf_drain_timeout cycles=%0d", n); end
    checks++;
    if (busy_cnt != 17*FL) begin failures++; $display("FAIL ovf_frames busy=%0d exp=%0d", busy_cnt, 17*FL); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d1;
    int         busy_cnt;
    d1 = 8'($urandom);
    @(negedge clk); wr_en = 1'b1; wr_data = d1;
    @(negedge clk); wr_data = 8'($urandom);
    @(negedge clk); wr_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_start busy=%b exp=1", busy); end
    repeat (4*DIV + 1) @(negedge clk);
    checks++;
    if (uart_tx !== d1[3] || count !== CW'(1)) begin
      failures++; $display("FAIL mid_bit3 tx=%b count=%0d exp %b,1", uart_tx, count, d1[3]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || count !== '0 || empty !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_async tx=%b count=%0d empty=%b busy=%b exp 1,0,1,0", uart_tx, count, empty, busy);
    end
    @(negedge clk); reset = 1'b1; wr_en = 1'b1; wr_data = 8'($urandom);
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL clean_start tx=%b busy=%b exp 0,1", uart_tx, busy);
    end
    busy_cnt = 1;
    for (int k = 1; k < FL + 3; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL model_clean t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    checks++;
    if (busy_cnt != FL) begin failures++; $display("FAIL clean_len busy=%0d exp=%0d", busy_cnt, FL); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] pat [2];
    logic       exp_par [2];
    logic       par_s;
    int         busy_cnt;
    pat[0] = 8'h07; exp_par[0] = 1'b1;
    pat[1] = 8'h03; exp_par[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = pat[p];
      @(negedge clk); wr_en = 1'b0;
      @(negedge clk);
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      par_s    = 1'bx;
      for (int k = 1; k < FL + 3; k++) begin
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        if (k == 9*DIV + DIV/2) par_s = uart_tx;
      end
      checks++;
      if (par_s !== exp_par[p]) begin
        failures++; $display("FAIL parity_%02h got=%b exp=%b", pat[p], par_s, exp_par[p]);
      end
      checks++;
      if (busy_cnt != 44) begin failures++; $display("FAIL parity_len got=%0d exp=44", busy_cnt); end
    end
  endtask
`endif

  task automatic test_random();
    int n;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL model_rand t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
      wr_en   = ($urandom_range(0, 99) < 5);
      wr_data = 8'($urandom);
    end
    @(negedge clk);
    wr_en = 1'b0;
    n     = 0;
    while ((busy !== 1'b0 || empty !== 1'b1) && n < 20*FL) begin
      @(negedge clk);
      n++;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL model_drain t=%0t dut=%b model=%b", $time, dut_vec, model_vec());
      end
    end
    checks++;
    if (n >= 20*FL) begin failures++; $display("FAIL rand_drain_timeout cycles=%0d", n); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog time=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
